// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, instruction field positions and fetch FSM encoding
package cpu_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int OPC_LSB = 26;
  localparam int OPC_W = 6;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int FIELD_W = 5;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, VALID = 2'd2} state_e;
endpackage

// File: rtl/operand_bypass.sv
// operand_bypass: selects zero, forwarded writeback data or register-file data for one operand
module operand_bypass #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data_o
);
  // idx_i != 0 in the forward branch also filters writebacks to register 0
  assign data_o = (idx_i == '0) ? '0 :
                  (wb_valid_i && wb_rd_i == idx_i) ? wb_data_i : rf_data_i;
endmodule

// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: latches an instruction, reads both source operands with writeback
// forwarding, and holds the operand bundle until downstream accepts it
module operand_fetch_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] rf_rs,
  output logic [ADDR_W-1:0] rf_rt,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_rd,
  output logic [OPC_W-1:0]  op_opcode
);
  state_e state_q, state_d;
  logic [31:RD_LSB] instr_q;
  logic [DATA_W-1:0] op_a_q, op_b_q, byp_a, byp_b;
  logic [ADDR_W-1:0] op_rd_q;
  logic [OPC_W-1:0] op_opcode_q;
  logic wb_en, unused_low_bits;
  assign unused_low_bits = ^instr[RD_LSB-1:0];
  assign rf_rs = ADDR_W'(instr_q[RS_LSB +: FIELD_W]);
  assign rf_rt = ADDR_W'(instr_q[RT_LSB +: FIELD_W]);
  // Writeback passes straight through in every state; gated off while reset is held
  assign wb_en = wb_valid && wb_rd != '0 && !rst;
  assign rf_rd = wb_en ? wb_rd : '0;
  assign rf_wdata = wb_en ? wb_data : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE && instr_valid) ? READ :
              (state_q == READ) ? VALID :
              (state_q == VALID && out_ready) ? IDLE : state_q;
  end
  always_comb begin
    instr_ready = state_q == IDLE;
    out_valid = state_q == VALID;
  end
  operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_a (
    .idx_i(rf_rs), .rf_data_i(rf_rdata_a), .wb_valid_i(wb_valid),
    .wb_rd_i(wb_rd), .wb_data_i(wb_data), .data_o(byp_a)
  );
  operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_b (
    .idx_i(rf_rt), .rf_data_i(rf_rdata_b), .wb_valid_i(wb_valid),
    .wb_rd_i(wb_rd), .wb_data_i(wb_data), .data_o(byp_b)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      op_rd_q <= '0;
      op_opcode_q <= '0;
    end else begin
      if (state_q == IDLE && instr_valid) instr_q <= instr[31:RD_LSB];
      if (state_q == READ) begin
        op_a_q <= byp_a;
        op_b_q <= byp_b;
        op_rd_q <= ADDR_W'(instr_q[RD_LSB +: FIELD_W]);
        op_opcode_q <= instr_q[OPC_LSB +: OPC_W];
      end
    end
  end
  assign op_a = op_a_q;
  assign op_b = op_b_q;
  assign op_rd = op_rd_q;
  assign op_opcode = op_opcode_q;
endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb_operand_fetch_unit: vector table plus hand sequences for backpressure and reset
module tb_operand_fetch_unit;
  logic clk = 0, rst, instr_valid, instr_ready, wb_valid, out_valid, out_ready;
  logic [31:0] instr, rf_wdata, rf_rdata_a, rf_rdata_b, wb_data, op_a, op_b;
  logic [4:0] rf_rs, rf_rt, rf_rd, wb_rd, op_rd;
  logic [5:0] op_opcode;
  int errors = 0, checks = 0;
  typedef struct {
    logic [4:0] rs, rt, rd; logic [5:0] opc; logic [31:0] ra, rb;
    logic wbv; logic [4:0] wbrd; logic [31:0] wbd, ea, eb; logic [4:0] erfrd; logic [31:0] ewd;
  } vec_t;
  typedef struct {logic [31:0] a, b; logic [4:0] rd; logic [5:0] opc;} exp_t;
  exp_t sb[$];
  vec_t vecs[7];

  operand_fetch_unit #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
    .op_rd(op_rd), .op_opcode(op_opcode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] rs, rt, rd);
    return {opc, rs, rt, rd, 11'h5A5};
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    instr_valid = 1; instr = mk(v.opc, v.rs, v.rt, v.rd);
    rf_rdata_a = v.ra; rf_rdata_b = v.rb; out_ready = 1; wb_valid = 0;
    #1 chk("ready_idle", 32'(instr_ready), 1);
    @(posedge clk);
    sb.push_back('{v.ea, v.eb, v.rd, v.opc});
    #1 instr_valid = 0; wb_valid = v.wbv; wb_rd = v.wbrd; wb_data = v.wbd;
    #1 chk("ready_read", 32'(instr_ready), 0);
    chk("valid_read", 32'(out_valid), 0);
    chk("rf_rs", 32'(rf_rs), 32'(v.rs));
    chk("rf_rt", 32'(rf_rt), 32'(v.rt));
    chk("rf_rd_read", 32'(rf_rd), 32'(v.erfrd));
    chk("rf_wdata_read", rf_wdata, v.ewd);
    @(posedge clk);
    #1 wb_valid = 0;
    chk("valid_2edges", 32'(out_valid), 1);
    chk("ready_valid", 32'(instr_ready), 0);
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL sb_underflow: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      chk("op_a", op_a, e.a);
      chk("op_b", op_b, e.b);
      chk("op_rd", 32'(op_rd), 32'(e.rd));
      chk("op_opcode", 32'(op_opcode), 32'(e.opc));
    end
    @(posedge clk);
    #1 chk("ready_back", 32'(instr_ready), 1);
    chk("valid_drop", 32'(out_valid), 0);
  endtask

  initial begin
    //           rs  rt  rd  opc    ra            rb            wbv wbrd wbd          ea           eb           erfrd ewd
    vecs[0] = '{8,  9,  3,  6'h01, 32'h11,       32'h22,       0,  0,   32'h0,       32'h11,      32'h22,      0,  32'h0};
    vecs[1] = '{8,  9,  4,  6'h02, 32'h11,       32'h22,       1,  8,   32'hDEAD,    32'hDEAD,    32'h22,      8,  32'hDEAD};
    vecs[2] = '{0,  0,  0,  6'h03, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,  0,   32'h1234,    32'h0,       32'h0,       0,  32'h0};
    vecs[3] = '{5,  7,  1,  6'h3F, 32'hA,        32'hB,        1,  7,   32'hBEEF,    32'hA,       32'hBEEF,    7,  32'hBEEF};
    vecs[4] = '{6,  6,  2,  6'h10, 32'h1,        32'h2,        1,  6,   32'hCAFE,    32'hCAFE,    32'hCAFE,    6,  32'hCAFE};
    vecs[5] = '{12, 12, 31, 6'h20, 32'h77,       32'h77,       1,  13,  32'h99,      32'h77,      32'h77,      13, 32'h99};
    vecs[6] = '{0,  3,  5,  6'h05, 32'hFF,       32'h33,       0,  3,   32'h44,      32'h0,       32'h33,      0,  32'h0};
    rst = 1; instr_valid = 0; instr = 0; out_ready = 0;
    rf_rdata_a = 0; rf_rdata_b = 0; wb_valid = 1; wb_rd = 3; wb_data = 32'h5;
    #2;
    chk("rst_ready", 32'(instr_ready), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_rf_rd", 32'(rf_rd), 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_op_a", op_a, 0);
    #10 rst = 0; wb_valid = 0;
    @(posedge clk); #1;
    foreach (vecs[i]) run_vec(vecs[i]);
    // writeback in IDLE with nothing offered
    wb_valid = 1; wb_rd = 9; wb_data = 32'h1357;
    #1 chk("idle_rf_rd", 32'(rf_rd), 9);
    chk("idle_rf_wdata", rf_wdata, 32'h1357);
    @(posedge clk); #1;
    chk("idle_stay", 32'(instr_ready), 1);
    chk("idle_no_valid", 32'(out_valid), 0);
    wb_valid = 0;
    // backpressure: held bundle must ignore writebacks to its source
    instr_valid = 1; instr = mk(6'h2A, 10, 11, 12); rf_rdata_a = 32'h100; rf_rdata_b = 32'h200; out_ready = 0;
    @(posedge clk); #1 instr_valid = 0;
    @(posedge clk); #1 rf_rdata_a = 32'hBAD; rf_rdata_b = 32'hBAD;
    wb_valid = 1; wb_rd = 10; wb_data = 32'h55;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_op_a", op_a, 32'h100);
      chk("bp_op_b", op_b, 32'h200);
      chk("bp_ready", 32'(instr_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_rf_rd", 32'(rf_rd), 10);
      chk("bp_rf_wdata", rf_wdata, 32'h55);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_ready_after", 32'(instr_ready), 1);
    chk("bp_valid_after", 32'(out_valid), 0);
    wb_valid = 0;
    // reset pulse while in READ drops the instruction
    instr_valid = 1; instr = mk(6'h11, 4, 5, 6); rf_rdata_a = 32'h44; rf_rdata_b = 32'h66;
    @(posedge clk); #1 instr_valid = 0; wb_valid = 1; wb_rd = 4; wb_data = 32'h77;
    #1 rst = 1;
    #1 chk("mid_rst_ready", 32'(instr_ready), 1);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_op_a", op_a, 0);
    chk("mid_rst_op_b", op_b, 0);
    chk("mid_rst_op_rd", 32'(op_rd), 0);
    chk("mid_rst_opc", 32'(op_opcode), 0);
    chk("mid_rst_rf_rd", 32'(rf_rd), 0);
    chk("mid_rst_rf_rs", 32'(rf_rs), 0);
    #1 rst = 0; wb_valid = 0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(instr_ready), 1);
    chk("post_rst_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("post_rst_valid2", 32'(out_valid), 0);
    chk("post_rst_op_a", op_a, 0);
    run_vec(vecs[1]);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
